// File: rtl/mips_cpu_multdiv.sv
// MIPS multiply/divide unit: iterative shift-add multiply, restoring divide, HI/LO registers.
// Define MULTDIV_FAST_MULT_EN to compute MULT/MULTU combinationally in one cycle.
module mips_cpu_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               signed_op, rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign signed_op = ~op[0];
    assign rs_neg    = signed_op & rs_data[WIDTH-1];
    assign rt_neg    = signed_op & rt_data[WIDTH-1];
    assign rs_abs    = rs_neg ? -rs_data : rs_data;
    assign rt_abs    = rt_neg ? -rt_data : rt_data;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    assign rem_sh   = {rem_q, acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {2'b00, opb_q};

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_hi_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

`ifdef MULTDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    always_comb begin
        if (signed_op) begin
            fast_prod = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
        end else begin
            fast_prod = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
`ifdef MULTDIV_FAST_MULT_EN
                            hi_d    = fast_prod[2*WIDTH-1:WIDTH];
                            lo_d    = fast_prod[WIDTH-1:0];
                            state_d = S_DONE;
`else
                            acc_d    = {{WIDTH{1'b0}}, rt_abs};
                            opb_d    = rs_abs;
                            neg_lo_d = rs_neg ^ rt_neg;
                            is_div_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_MUL;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            if (rt_data == '0) begin
                                hi_d    = rs_data;
                                lo_d    = '1;
                                dbz_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                acc_d    = {{WIDTH{1'b0}}, rs_abs};
                                rem_d    = '0;
                                opb_d    = rt_abs;
                                neg_lo_d = rs_neg ^ rt_neg;
                                neg_hi_d = rs_neg;
                                is_div_d = 1'b1;
                                cnt_d    = '0;
                                state_d  = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d    = rs_data;
                            state_d = S_DONE;
                        end
                        OP_MTLO: begin
                            lo_d    = rs_data;
                            state_d = S_DONE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                if (rem_diff[WIDTH+1]) begin
                    rem_d = rem_sh[WIDTH:0];
                end else begin
                    rem_d = rem_diff[WIDTH:0];
                end
                acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~rem_diff[WIDTH+1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Self-checking bench for mips_cpu_multdiv: directed vector table, corner sequences,
// and randomized operations checked against a plain-arithmetic HI/LO model.
module tb_mips_cpu_multdiv;
    localparam int WIDTH = 32;
`ifdef MULTDIV_FAST_MULT_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [2:0]  op      = 3'b000;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    always #5 clk = ~clk;

    mips_cpu_multdiv #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .op         (op),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Cycles from accept edge to the edge after which done is seen; -1 = no done.
    function automatic int lat_of(input logic [2:0] o, input logic [31:0] b);
        case (o)
            3'b000, 3'b001: return MUL_LAT;
            3'b010, 3'b011: return (b == 32'd0) ? 0 : DIV_LAT;
            3'b100, 3'b101: return 0;
            default:        return -1;
        endcase
    endfunction

    function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] ph, input logic [31:0] pl,
                                      output logic [31:0] h, output logic [31:0] l, output logic d);
        longint          sa, sb, q, rm;
        longint unsigned ua, ub, uq, urm;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        h  = ph;
        l  = pl;
        d  = 1'b0;
        case (o)
            3'b000: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            3'b001: begin p = ua * ub;      h = p[63:32]; l = p[31:0]; end
            3'b010, 3'b011: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF; d = 1'b1;
                end else if (o == 3'b010) begin
                    q = sa / sb; rm = sa % sb;
                    l = q[31:0]; h = rm[31:0];
                end else begin
                    uq = ua / ub; urm = ua % ub;
                    l = uq[31:0]; h = urm[31:0];
                end
            end
            3'b100: h = a;
            3'b101: l = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input int gap, input int intrude, input string tag);
        int lat;
        int busy_cnt;
        bit early;
        bit moved;
        lat      = lat_of(o, b);
        busy_cnt = 0;
        early    = 1'b0;
        moved    = 1'b0;
        if (gap > 0) begin
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            check({tag, " idle_flags"}, {61'd0, done, busy, div_by_zero}, 64'd0);
        end
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 3'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
        if (lat < 0) begin
            check({tag, " rsv_flags"}, {62'd0, done, busy}, 64'd0);
            check({tag, " rsv_hilo"}, {hi, lo}, {cur_hi, cur_lo});
            $display("op=%0d rs=%h rt=%h -> ignored", o, a, b);
            return;
        end
        for (int c = 0; c < lat; c++) begin
            if (busy) busy_cnt++;
            if (done) early = 1'b1;
            if (hi !== cur_hi || lo !== cur_lo) moved = 1'b1;
            if (c == intrude) begin
                start   = 1'b1;
                op      = 3'b101;
                rs_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat));
        check({tag, " early_done"}, {63'd0, early}, 64'd0);
        check({tag, " hilo_held"}, {63'd0, moved}, 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, el});
        check({tag, " dbz"}, {63'd0, div_by_zero}, {63'd0, ed});
        cur_hi = eh;
        cur_lo = el;
        $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h dbz=%0d", o, a, b, hi, lo, div_by_zero);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb, eh, el;
        logic        ed;
        bit          seen;

        tbl[0]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1]  = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3]  = '{3'b011, 32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 32'h2AAA_AAAA, 1'b0};
        tbl[4]  = '{3'b010, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        tbl[5]  = '{3'b011, 32'h0000_0009, 32'h0000_0002, 32'h0000_0001, 32'h0000_0004, 1'b0};
        tbl[6]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[7]  = '{3'b100, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000, 1'b0};
        tbl[8]  = '{3'b101, 32'hCAFE_F00D, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 1'b0};
        tbl[9]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        tbl[10] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[11] = '{3'b000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        tbl[12] = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[13] = '{3'b001, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, alternating back-to-back and idle gaps
        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz,
                  i % 2, -1, $sformatf("vec%0d", i));
        end

        // Reserved op is ignored
        do_op(3'b110, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 1'b0, 1, -1, "rsv110");
        do_op(3'b111, 32'h3333_3333, 32'h4444_4444, 32'h0, 32'h0, 1'b0, 0, -1, "rsv111");

        // MTHI in MULTU's DONE cycle, then a start during busy is ignored
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1, -1, "b2b_multu");
        do_op(3'b100, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0000_0001, 1'b0, 0, -1, "b2b_mthi");
        do_op(3'b001, 32'h0001_0000, 32'h0001_0003, 32'h0000_0001, 32'h0003_0000, 1'b0, 0, 4, "intrude_multu");
        do_op(3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 0, 9, "intrude_divu");

        // Reset mid-operation
        do_op(3'b100, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, cur_lo, 1'b0, 1, -1, "pre_rst_mthi");
        @(negedge clk);
        start = 1'b1;
`ifdef MULTDIV_FAST_MULT_EN
        op = 3'b011; rs_data = 32'd100; rt_data = 32'd7;
`else
        op = 3'b001; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_rst flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("midop_rst hi", {32'd0, hi}, 64'd0);
        check("midop_rst lo", {32'd0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        cur_hi = '0;
        cur_lo = '0;
        seen   = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("midop_rst no_done", {63'd0, seen}, 64'd0);
        $display("reset mid-operation -> hi=%h lo=%h", hi, lo);

        // Randomized operations against the reference model
        for (int i = 0; i < 200; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            ref_model(ro, ra, rb, cur_hi, cur_lo, eh, el, ed);
            do_op(ro, ra, rb, eh, el, ed, int'($urandom_range(0, 2)), -1, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_multdiv.md
# mips_cpu_multdiv

Multiply/divide unit with architectural HI/LO registers for the MIPS core. Consumes the two operands read out of the register file (`RsDATA`/`RtDATA`) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide are iterative, one bit per cycle. HI/LO are exposed to the writeback path for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; the parameter exists for the bench.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `start`  in  1  request; sampled only while `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- `rs_data`  in  32  Rs operand (dividend, multiplicand, MTHI/MTLO source).
- `rt_data`  in  32  Rt operand (divisor, multiplier).
- `busy`  out  1  iteration in progress.
- `done`  out  1  one-cycle pulse; HI/LO updated and valid.
- `div_by_zero`  out  1  qualifies `done`; valid while `done`=1, otherwise 0.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- DONE lasts one cycle with `done`=1. It accepts `start` exactly as IDLE does.
- Accepting `start` in IDLE/DONE:
  - MULT/MULTU: capture operands; go to MUL.
  - DIV/DIVU with `rt_data`≠0: capture operands; go to DIV.
  - DIV/DIVU with `rt_data`=0: write HI←`rs_data` and LO←0xFFFFFFFF; go to DONE with `div_by_zero`=1.
  - MTHI/MTLO: write HI (or LO) ←`rs_data`; go to DONE.
  - Reserved `op`: ignored; stay in IDLE. No `done`.
- `start` while `busy`=1 is ignored. Operands are not re-sampled.
- Signed ops (MULT, DIV):
  - Capture the absolute values and record the sign flags, then iterate unsigned.
  - Product sign = XOR of the operand signs.
  - Quotient sign = XOR of the operand signs. Remainder sign = dividend sign (truncating division).
- MUL: shift-add over a 64-bit accumulator, 32 iterations, then FIX.
- DIV: restoring division with a 33-bit partial remainder, 32 iterations, then FIX.
- FIX:
  - Apply two's-complement negation where the sign flags require it.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: HI = remainder, LO = quotient.
  - Go to DONE.
- HI/LO hold their previous values for the whole operation. They are written only at the FIX→DONE edge, or at the single-cycle write edges above.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No exception is raised.

## Timing
- Reset asserted: state IDLE; `hi`=`lo`=0; `busy`=`done`=`div_by_zero`=0.
- Reset mid-operation: the in-flight result is discarded and all the values above apply immediately.
- `start` is accepted at edge k:
  - Iterations run at edges k+1 through k+32. FIX runs at edge k+33.
  - `busy`=1 in the cycles following edges k through k+32 (33 cycles).
  - `done`=1 in the cycle following edge k+33, with `busy`=0 and the new HI/LO visible.
- Single-cycle paths (MTHI, MTLO, divide-by-zero): HI/LO write at edge k; `done`=1 in the cycle after edge k; `busy` never rises.
- Back-to-back: `start` during the DONE cycle is accepted at that edge, so there are no bubbles.

## Configuration
- `MULTDIV_FAST_MULT_EN` defined:
  - MULT/MULTU compute the 64-bit product combinationally at the accept edge.
  - HI/LO are written at edge k, `done` appears in the cycle after, and `busy` never rises.
  - MUL state is unused.
- Not defined: MULT/MULTU take the 34-edge iterative path.
- Divide timing is identical in both builds.

## Test plan
- Reset: drive `reset`=0 mid-MULTU (edge k+10) → `busy`=`done`=0, `hi`=`lo`=0 immediately. No `done` after `reset` is released.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `done` in the cycle after edge k+33; `hi`=0xFFFFFFFE, `lo`=0x00000001. `busy` is high for exactly 33 cycles (fast build: `done` in the cycle after edge k).
- MULT 0xFFFFFFFD×0x00000007 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV 0xFFFFFFF9÷0x00000002 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 0x80000000÷3 → `lo`=0x2AAAAAAA, `hi`=0x00000002.
- DIV 5÷0 → `done`=1 and `div_by_zero`=1 in the cycle after the accept edge; `hi`=5, `lo`=0xFFFFFFFF. The next DIVU 9÷2 has `div_by_zero`=0.
- MTHI 0x12345678 accepted during MULTU's DONE cycle, then a second `start` issued at edge k+5 of a new MULTU → `hi`=0x12345678 with `done` one cycle later. The edge-k+5 `start` is ignored, and the MULTU result is unchanged.
